rr_arbiter_n: RTL and testbench

- Round-robin arbiter with a registered output stage; sits directly upstream of the library N-to-1 data mux path.
- Accepts up to N valid/ready request streams of M-bit data and picks one winner per accept slot with a fair rotating priority.
- Presents the winner's data, index and one-hot grant through a single valid/ready output register.
- The downstream consumer sees a clean, stalled-safe stream plus a select index compatible with N-to-1 mux select encoding.

---
 rtl/arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 40 ++++
 rtl/rr_arbiter_n.sv | 69 ++++++
 tb/tb_rr_arbiter_n.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared helpers for arbiter blocks: select-width sizing and index-to-one-hot decode.
package arb_pkg;

    // Widest requester vector the one-hot helper supports.
    localparam int MAX_N = 64;

    // Width of an index able to address n requesters; never below one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One-hot decode of an index; callers slice the low N bits they need.
    function automatic logic [MAX_N-1:0] idx_to_onehot(input int unsigned idx);
        logic [MAX_N-1:0] one;
        one = 1;
        return one << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping modulo N.
module rr_pick
    import arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = sel_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          found,
    output logic [SW-1:0] idx,
    output logic [N-1:0]  onehot
);

    logic [N-1:0]     masked;
    logic [2*N-1:0]   dbl;
    logic [MAX_N-1:0] oh_full;
    int               pos;

    // Double-width encode: the low copy holds requests at or above ptr, the high copy
    // holds all requests, so the lowest set bit is the winner in rotated order.
    always_comb begin
        masked = '0;
        for (int i = 0; i < N; i++) begin
            masked[i] = req[i] && (i >= int'(ptr));
        end
        dbl = {req, masked};
        pos = 0;
        for (int j = 2 * N - 1; j >= 0; j--) begin
            if (dbl[j]) begin
                pos = j;
            end
        end
        found   = |req;
        idx     = (pos >= N) ? SW'(pos - N) : SW'(pos);
        oh_full = idx_to_onehot(32'(idx));
        onehot  = found ? oh_full[N-1:0] : '0;
    end

endmodule

// File: rtl/rr_arbiter_n.sv
// Round-robin N-to-1 arbiter with a single registered valid/ready output stage.
//
// Handshake: an item moves across an interface on a rising edge where both valid
// and ready are high. Senders hold valid and data stable until that edge; ready
// may depend combinationally on valid (req_ready does), valid never depends on ready.
module rr_arbiter_n
    import arb_pkg::*;
#(
    parameter  int N            = 4,
    parameter  int M            = 8,
    localparam int SELECT_WIDTH = sel_width(N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [N-1:0]            req_valid,
    input  logic [M-1:0]            req_data [N-1:0],
    output logic [N-1:0]            req_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [M-1:0]            out_data,
    output logic [SELECT_WIDTH-1:0] out_select,
    output logic [N-1:0]            out_grant
);

    logic [SELECT_WIDTH-1:0] ptr;
    logic [SELECT_WIDTH-1:0] pick_idx;
    logic                    pick_found;
    logic [N-1:0]            pick_onehot;
    logic                    load;
    logic                    xfer;
    logic [MAX_N-1:0]        grant_full;

    rr_pick #(.N(N)) u_pick (
        .req    (req_valid),
        .ptr    (ptr),
        .found  (pick_found),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // Accept slot exists when enabled and the output register is empty or draining;
    // reset also blocks accepts so nothing is granted while the block is held.
    always_comb begin
        load       = enable && (!out_valid || out_ready);
        xfer       = rst_n && load && pick_found;
        req_ready  = xfer ? pick_onehot : '0;
        grant_full = idx_to_onehot(32'(out_select));
        out_grant  = out_valid ? grant_full[N-1:0] : '0;
    end

    // Output register and priority pointer; ptr moves past the winner only on a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_select <= '0;
            ptr        <= '0;
        end else if (xfer) begin
            out_valid  <= 1'b1;
            out_data   <= req_data[pick_idx];
            out_select <= pick_idx;
            ptr        <= (pick_idx == SELECT_WIDTH'(N - 1)) ? '0 : pick_idx + 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Directed bench for rr_arbiter_n: a per-cycle vector table on an N=4 instance,
// plus hand-written reset and rotation sequences on an N=3 instance.
module tb_rr_arbiter_n;

    typedef struct {
        logic       en;
        logic [3:0] rv;
        logic       ordy;
        logic [3:0] rr;
        logic       ov;
        logic [7:0] od;
        logic [1:0] os;
        logic [3:0] og;
    } vec_t;

    logic       clk;
    logic       rst_n;

    // N=4 instance
    logic       enable;
    logic [3:0] req_valid;
    logic [7:0] req_data [3:0];
    logic [3:0] req_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] out_select;
    logic [3:0] out_grant;

    // N=3 instance
    logic       enable3;
    logic [2:0] req_valid3;
    logic [7:0] req_data3 [2:0];
    logic [2:0] req_ready3;
    logic       out_valid3;
    logic       out_ready3;
    logic [7:0] out_data3;
    logic [1:0] out_select3;
    logic [2:0] out_grant3;

    int n_checks;
    int n_fail;
    vec_t vecs[$];

    rr_arbiter_n #(.N(4), .M(8)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_select (out_select),
        .out_grant  (out_grant)
    );

    rr_arbiter_n #(.N(3), .M(8)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable3),
        .req_valid  (req_valid3),
        .req_data   (req_data3),
        .req_ready  (req_ready3),
        .out_valid  (out_valid3),
        .out_ready  (out_ready3),
        .out_data   (out_data3),
        .out_select (out_select3),
        .out_grant  (out_grant3)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic [3:0] rv, input logic ordy,
                                input logic [3:0] rr, input logic ov, input logic [7:0] od,
                                input logic [1:0] os, input logic [3:0] og);
        vec_t v;
        v.en = en; v.rv = rv; v.ordy = ordy; v.rr = rr;
        v.ov = ov; v.od = od; v.os = os; v.og = og;
        return v;
    endfunction

    // Called just after a falling edge: drive, check combinational ready, clock, check outputs.
    task automatic run_vec(input int k, input vec_t v);
        enable    = v.en;
        req_valid = v.rv;
        out_ready = v.ordy;
        #1;
        check($sformatf("v%0d req_ready", k), 32'(req_ready), 32'(v.rr));
        @(posedge clk);
        #1;
        check($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(v.ov));
        check($sformatf("v%0d out_data", k), 32'(out_data), 32'(v.od));
        check($sformatf("v%0d out_select", k), 32'(out_select), 32'(v.os));
        check($sformatf("v%0d out_grant", k), 32'(out_grant), 32'(v.og));
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 4; i++) req_data[i] = 8'hA0 + 8'(i);
        for (int i = 0; i < 3; i++) req_data3[i] = 8'hB0 + 8'(i);

        // Rotation and latency
        vecs.push_back(mk(1, 4'b1111, 1, 4'b0001, 1, 8'hA0, 2'd0, 4'b0001));
        vecs.push_back(mk(1, 4'b1111, 1, 4'b0010, 1, 8'hA1, 2'd1, 4'b0010));
        vecs.push_back(mk(1, 4'b1111, 1, 4'b0100, 1, 8'hA2, 2'd2, 4'b0100));
        vecs.push_back(mk(1, 4'b1111, 1, 4'b1000, 1, 8'hA3, 2'd3, 4'b1000));
        vecs.push_back(mk(1, 4'b1111, 1, 4'b0001, 1, 8'hA0, 2'd0, 4'b0001));
        // Skip and wrap: grant 1 leaves ptr=2, then 0, then 1, then 3 wrapping ptr to 0
        vecs.push_back(mk(1, 4'b0010, 1, 4'b0010, 1, 8'hA1, 2'd1, 4'b0010));
        vecs.push_back(mk(1, 4'b0011, 1, 4'b0001, 1, 8'hA0, 2'd0, 4'b0001));
        vecs.push_back(mk(1, 4'b0011, 1, 4'b0010, 1, 8'hA1, 2'd1, 4'b0010));
        vecs.push_back(mk(1, 4'b1000, 1, 4'b1000, 1, 8'hA3, 2'd3, 4'b1000));
        // Drain with no refill keeps data/select
        vecs.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, 8'hA3, 2'd3, 4'b0000));
        // Backpressure: load into empty register, hold 5 cycles, reload on release
        vecs.push_back(mk(1, 4'b0100, 0, 4'b0100, 1, 8'hA2, 2'd2, 4'b0100));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 4'b0100, 0, 4'b0000, 1, 8'hA2, 2'd2, 4'b0100));
        vecs.push_back(mk(1, 4'b0100, 1, 4'b0100, 1, 8'hA2, 2'd2, 4'b0100));
        vecs.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, 8'hA2, 2'd2, 4'b0000));
        // Enable gating on an empty register; ptr=3 must survive, so 0 wins next then 1
        vecs.push_back(mk(0, 4'b0001, 1, 4'b0000, 0, 8'hA2, 2'd2, 4'b0000));
        vecs.push_back(mk(0, 4'b0001, 1, 4'b0000, 0, 8'hA2, 2'd2, 4'b0000));
        vecs.push_back(mk(1, 4'b0001, 1, 4'b0001, 1, 8'hA0, 2'd0, 4'b0001));
        vecs.push_back(mk(1, 4'b1111, 1, 4'b0010, 1, 8'hA1, 2'd1, 4'b0010));
        // Enable falls while holding: hold under stall, drain, then resume from ptr=2
        vecs.push_back(mk(0, 4'b1111, 0, 4'b0000, 1, 8'hA1, 2'd1, 4'b0010));
        vecs.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 8'hA1, 2'd1, 4'b0000));
        vecs.push_back(mk(1, 4'b1111, 1, 4'b0100, 1, 8'hA2, 2'd2, 4'b0100));

        // Reset held with all requesters valid
        rst_n      = 1'b0;
        enable     = 1'b1;
        req_valid  = 4'b1111;
        out_ready  = 1'b1;
        enable3    = 1'b1;
        req_valid3 = 3'b000;
        out_ready3 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset out_grant", 32'(out_grant), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset out_select", 32'(out_select), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            run_vec(k, vecs[k]);
        end

        // N=3: seven back-to-back transfers with all valid
        enable    = 1'b1;
        req_valid = 4'b0000;
        req_valid3 = 3'b111;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("n3 t%0d out_valid", k), 32'(out_valid3), 32'd1);
            check($sformatf("n3 t%0d out_select", k), 32'(out_select3), 32'(k % 3));
            check($sformatf("n3 t%0d out_data", k), 32'(out_data3), 32'(8'hB0 + 8'(k % 3)));
        end

        // Mid-stream async reset: outputs clear without waiting for an edge
        #2;
        rst_n = 1'b0;
        #1;
        check("n3 async out_valid", 32'(out_valid3), 32'd0);
        check("n3 async out_select", 32'(out_select3), 32'd0);
        check("n3 async out_data", 32'(out_data3), 32'd0);
        check("n3 async out_grant", 32'(out_grant3), 32'd0);
        check("n3 async req_ready", 32'(req_ready3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("n3 restart req_ready", 32'(req_ready3), 32'b001);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("n3 r%0d out_select", k), 32'(out_select3), 32'(k));
            check($sformatf("n3 r%0d out_grant", k), 32'(out_grant3), 32'(1 << k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
